// File: rtl/ip_hdr_assembler_arb.sv
// Packet-granular round-robin arbiter that shares the IP header assembler between NUM_SRC tx engines.
// Optional per-source granted-packet counters are built when IP_HDR_ASSEMBLER_ARB_STATS_EN is defined.
package ip_hdr_assembler_arb_pkg;
  localparam int unsigned IP_ADDR_W       = 32;
  localparam int unsigned TOT_LEN_W       = 16;
  localparam int unsigned PROTOCOL_W      = 8;
  localparam int unsigned MAC_INTERFACE_W = 64;
  localparam int unsigned MAC_PADBYTES_W  = $clog2(MAC_INTERFACE_W / 8);
  localparam int unsigned PKT_CNT_W       = 32;

  typedef struct packed {
    logic [31:0] pkt_start;
    logic [31:0] req_time;
  } tracker_stats_struct;
endpackage

module ip_hdr_assembler_arb
  import ip_hdr_assembler_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned SRC_ID_W = $clog2(NUM_SRC)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                [NUM_SRC-1:0]           src_arb_req_val,
  input  logic                [NUM_SRC-1:0][IP_ADDR_W-1:0]  src_arb_src_ip_addr,
  input  logic                [NUM_SRC-1:0][IP_ADDR_W-1:0]  src_arb_dst_ip_addr,
  input  logic                [NUM_SRC-1:0][TOT_LEN_W-1:0]  src_arb_data_payload_len,
  input  logic                [NUM_SRC-1:0][PROTOCOL_W-1:0] src_arb_protocol,
  input  tracker_stats_struct [NUM_SRC-1:0]           src_arb_timestamp,
  output logic                [NUM_SRC-1:0]           arb_src_req_rdy,
  input  logic                [NUM_SRC-1:0]           src_arb_data_val,
  input  logic                [NUM_SRC-1:0][MAC_INTERFACE_W-1:0] src_arb_data,
  input  logic                [NUM_SRC-1:0]           src_arb_data_last,
  input  logic                [NUM_SRC-1:0][MAC_PADBYTES_W-1:0]  src_arb_data_padbytes,
  output logic                [NUM_SRC-1:0]           arb_src_data_rdy,
  output logic                                        arb_asm_req_val,
  output logic                [IP_ADDR_W-1:0]         arb_asm_src_ip_addr,
  output logic                [IP_ADDR_W-1:0]         arb_asm_dst_ip_addr,
  output logic                [TOT_LEN_W-1:0]         arb_asm_data_payload_len,
  output logic                [PROTOCOL_W-1:0]        arb_asm_protocol,
  output tracker_stats_struct                         arb_asm_timestamp,
  input  logic                                        asm_arb_req_rdy,
  output logic                                        arb_asm_data_val,
  output logic                [MAC_INTERFACE_W-1:0]   arb_asm_data,
  output logic                                        arb_asm_data_last,
  output logic                [MAC_PADBYTES_W-1:0]    arb_asm_data_padbytes,
  input  logic                                        asm_arb_data_rdy,
  output logic                [SRC_ID_W-1:0]          arb_asm_src_id,
  output logic                [NUM_SRC-1:0][PKT_CNT_W-1:0] arb_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_OUT  = 2'd1,
    DATA_OUT = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SRC_ID_W-1:0] r_grant_id;
  logic [SRC_ID_W-1:0] w_grant_nxt;
  logic [SRC_ID_W-1:0] r_rr_ptr;
  logic [SRC_ID_W-1:0] w_rr_nxt;
  logic [SRC_ID_W-1:0] w_winner;
  logic                w_found;
  logic                w_req_hs;
  logic                w_last_hs;

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin : p_rr_pick
    int unsigned v_idx;
    v_idx    = 0;
    w_winner = r_rr_ptr;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % NUM_SRC;
      if (!w_found && src_arb_req_val[SRC_ID_W'(v_idx)]) begin
        w_winner = SRC_ID_W'(v_idx);
        w_found  = 1'b1;
      end
    end
  end

  assign w_req_hs  = (r_state == HDR_OUT) && src_arb_req_val[r_grant_id] && asm_arb_req_rdy;
  assign w_last_hs = (r_state == DATA_OUT) && src_arb_data_val[r_grant_id] && asm_arb_data_rdy
                     && src_arb_data_last[r_grant_id];

  always_ff @(posedge clk) begin : p_state_reg
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant_id <= w_grant_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  always_comb begin : p_next_out
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant_id;
    w_rr_nxt         = r_rr_ptr;
    arb_asm_req_val  = 1'b0;
    arb_src_req_rdy  = '0;
    arb_asm_data_val = 1'b0;
    arb_src_data_rdy = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_winner;
          w_state_nxt = HDR_OUT;
        end
      end
      HDR_OUT: begin
        arb_asm_req_val             = src_arb_req_val[r_grant_id];
        arb_src_req_rdy[r_grant_id] = asm_arb_req_rdy;
        if (w_req_hs) w_state_nxt = DATA_OUT;
      end
      DATA_OUT: begin
        arb_asm_data_val             = src_arb_data_val[r_grant_id];
        arb_src_data_rdy[r_grant_id] = asm_arb_data_rdy;
        if (w_last_hs) begin
          w_rr_nxt    = (r_grant_id == SRC_ID_W'(NUM_SRC - 1)) ? '0 : r_grant_id + SRC_ID_W'(1);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Handshakes must not be visible to either side while held in reset.
    if (!rst_n) begin
      arb_asm_req_val  = 1'b0;
      arb_src_req_rdy  = '0;
      arb_asm_data_val = 1'b0;
      arb_src_data_rdy = '0;
    end
  end

  assign arb_asm_src_ip_addr      = src_arb_src_ip_addr[r_grant_id];
  assign arb_asm_dst_ip_addr      = src_arb_dst_ip_addr[r_grant_id];
  assign arb_asm_data_payload_len = src_arb_data_payload_len[r_grant_id];
  assign arb_asm_protocol         = src_arb_protocol[r_grant_id];
  assign arb_asm_timestamp        = src_arb_timestamp[r_grant_id];
  assign arb_asm_data             = src_arb_data[r_grant_id];
  assign arb_asm_data_last        = src_arb_data_last[r_grant_id];
  assign arb_asm_data_padbytes    = src_arb_data_padbytes[r_grant_id];
  assign arb_asm_src_id           = r_grant_id;

`ifdef IP_HDR_ASSEMBLER_ARB_STATS_EN
  logic [NUM_SRC-1:0][PKT_CNT_W-1:0] r_pkt_cnt;

  // One count per accepted header request; wraps naturally.
  always_ff @(posedge clk) begin : p_pkt_cnt
    if (!rst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_req_hs) begin
      r_pkt_cnt[r_grant_id] <= r_pkt_cnt[r_grant_id] + PKT_CNT_W'(1);
    end
  end

  assign arb_pkt_cnt = r_pkt_cnt;
`else
  assign arb_pkt_cnt = '0;
`endif

endmodule
